// File: rtl/map_pkg.sv
`timescale 1ns/1ps
// Shared types, map geometry and address/layout helpers for the tile-map server.
package map_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BRICK = 2'd1,
    STEEL = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int MAP_W     = 40;
  localparam int MAP_H     = 30;
  localparam int MAP_CELLS = MAP_W * MAP_H;

  // y*40 + x built from shifts so no multiplier is inferred
  function automatic logic [10:0] tile_addr(input logic [5:0] x, input logic [5:0] y);
    return 11'({y, 5'b0}) + 11'({y, 3'b0}) + 11'(x);
  endfunction

  function automatic cell_t map_default(input logic [5:0] x, input logic [5:0] y);
    if (x == 6'd0 || x == 6'(MAP_W - 1) || y == 6'd0 || y == 6'(MAP_H - 1)) return STEEL;
    if (x[2:0] == 3'd4 && y[2:0] == 3'd4) return STEEL;
    if (x[1:0] == 2'd2 && y[1:0] == 2'd2) return BRICK;
    return EMPTY;
  endfunction

endpackage

// File: rtl/map_ram.sv
`timescale 1ns/1ps
// 1200x2 dual-port map store: port A is a registered read for VGA, port B a
// registered read/write (read-before-write) for the request FSM.
module map_ram
  import map_pkg::*;
(
  input  logic        clk,
  input  logic [10:0] i_a_addr,
  output logic [1:0]  o_a_q,
  input  logic [10:0] i_b_addr,
  input  logic        i_b_we,
  input  logic [1:0]  i_b_wd,
  output logic [1:0]  o_b_q
);

  // no reset on the array or read registers so the block maps onto M9K
  logic [1:0] r_mem [0:MAP_CELLS-1];
  logic [1:0] r_a_q;
  logic [1:0] r_b_q;

  always_ff @(posedge clk) begin
    r_a_q <= r_mem[i_a_addr];
  end

  always_ff @(posedge clk) begin
    if (i_b_we) r_mem[i_b_addr] <= i_b_wd;
    r_b_q <= r_mem[i_b_addr];
  end

  assign o_a_q = r_a_q;
  assign o_b_q = r_b_q;

endmodule

// File: rtl/map_server.sv
`timescale 1ns/1ps
// Tile-map server: sweeps the default layout into RAM, answers VGA wall
// lookups every cycle and game read/clear requests via valid/ack.
module map_server #(
  parameter int MAP_W = 40,
  parameter int MAP_H = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_new_game,
  input  logic        i_vga_busy,
  input  logic [5:0]  i_vga_x,
  input  logic [5:0]  i_vga_y,
  output logic        o_vga_is_wall,
  input  logic        i_req_valid,
  input  logic [5:0]  i_req_x,
  input  logic [5:0]  i_req_y,
  input  logic        i_req_clear,
  output logic        o_req_ack,
  output logic [1:0]  o_req_type,
  output logic        o_ready,
  output logic [10:0] o_brick_cnt
);
  import map_pkg::cell_t, map_pkg::state_t, map_pkg::EMPTY, map_pkg::BRICK,
         map_pkg::STEEL, map_pkg::INIT, map_pkg::IDLE, map_pkg::ACCESS,
         map_pkg::tile_addr, map_pkg::map_default;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_sx, r_sy;
  logic [10:0] r_addr;
  logic        r_oob, r_clr;
  logic        r_ready, r_ack;
  cell_t       r_req_type;
  logic [10:0] r_brick_cnt;
  logic        r_vga_oob, r_vga_is_wall;

  logic        w_vga_oob, w_req_oob, w_sweep_last, w_do_clear;
  cell_t       w_sweep_cell, w_acc_type;
  logic [10:0] w_a_addr, w_b_addr;
  logic        w_b_we;
  cell_t       w_b_wd;
  logic [1:0]  w_a_q, w_b_q;

  assign w_vga_oob    = (i_vga_x >= 6'(MAP_W)) || (i_vga_y >= 6'(MAP_H));
  assign w_req_oob    = (i_req_x >= 6'(MAP_W)) || (i_req_y >= 6'(MAP_H));
  // out-of-range lookups are steered to address 0 and overridden to STEEL
  assign w_a_addr     = w_vga_oob ? 11'd0 : tile_addr(i_vga_x, i_vga_y);
  assign w_sweep_cell = map_default(r_sx, r_sy);
  assign w_sweep_last = (r_sx == 6'(MAP_W - 1)) && (r_sy == 6'(MAP_H - 1));
  assign w_acc_type   = r_oob ? STEEL : cell_t'(w_b_q);
  assign w_do_clear   = r_clr && !r_oob && (w_acc_type == BRICK);

  map_ram u_ram (
    .clk      (clk),
    .i_a_addr (w_a_addr),
    .o_a_q    (w_a_q),
    .i_b_addr (w_b_addr),
    .i_b_we   (w_b_we),
    .i_b_wd   (w_b_wd),
    .o_b_q    (w_b_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_b_addr    = 11'd0;
    w_b_we      = 1'b0;
    w_b_wd      = EMPTY;
    case (r_state)
      INIT: begin
        w_b_addr = tile_addr(r_sx, r_sy);
        w_b_we   = 1'b1;
        w_b_wd   = w_sweep_cell;
        if (w_sweep_last) w_state_nxt = IDLE;
      end
      IDLE: begin
        // read issued speculatively so data is ready in the ACCESS cycle
        w_b_addr = w_req_oob ? 11'd0 : tile_addr(i_req_x, i_req_y);
        if (i_req_valid && !i_vga_busy) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        w_b_addr    = r_addr;
        w_b_we      = w_do_clear;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = INIT;
    endcase
    if (i_new_game) begin
      w_state_nxt = INIT;
      w_b_we      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx          <= '0;
      r_sy          <= '0;
      r_addr        <= '0;
      r_oob         <= 1'b0;
      r_clr         <= 1'b0;
      r_ready       <= 1'b0;
      r_ack         <= 1'b0;
      r_req_type    <= EMPTY;
      r_brick_cnt   <= '0;
      r_vga_oob     <= 1'b0;
      r_vga_is_wall <= 1'b0;
    end else begin
      r_ack         <= 1'b0;
      r_vga_oob     <= w_vga_oob;
      r_vga_is_wall <= r_ready && (r_vga_oob || (w_a_q != EMPTY));
      if (i_new_game) begin
        r_sx        <= '0;
        r_sy        <= '0;
        r_ready     <= 1'b0;
        r_brick_cnt <= '0;
      end else begin
        case (r_state)
          INIT: begin
            if (w_sweep_cell == BRICK) r_brick_cnt <= r_brick_cnt + 11'd1;
            if (w_sweep_last) begin
              r_ready <= 1'b1;
              r_sx    <= '0;
              r_sy    <= '0;
            end else if (r_sx == 6'(MAP_W - 1)) begin
              r_sx <= '0;
              r_sy <= r_sy + 6'd1;
            end else begin
              r_sx <= r_sx + 6'd1;
            end
          end
          IDLE: begin
            if (i_req_valid && !i_vga_busy) begin
              r_addr <= w_b_addr;
              r_oob  <= w_req_oob;
              r_clr  <= i_req_clear;
            end
          end
          ACCESS: begin
            r_ack      <= 1'b1;
            r_req_type <= w_acc_type;
            if (w_do_clear) r_brick_cnt <= r_brick_cnt - 11'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_vga_is_wall = r_vga_is_wall && r_ready;
  assign o_req_ack     = r_ack;
  assign o_req_type    = r_req_type;
  assign o_ready       = r_ready;
  assign o_brick_cnt   = r_brick_cnt;

endmodule

// File: tb/tb_map_server.sv
`timescale 1ns/1ps
// Directed bench for map_server: init sweep, VGA lookups, read/clear requests,
// busy hold-off, new-game restart and asynchronous reset.
module tb_map_server;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_new_game = 1'b0;
  logic        i_vga_busy = 1'b0;
  logic [5:0]  i_vga_x = '0, i_vga_y = '0;
  logic        o_vga_is_wall;
  logic        i_req_valid = 1'b0;
  logic [5:0]  i_req_x = '0, i_req_y = '0;
  logic        i_req_clear = 1'b0;
  logic        o_req_ack;
  logic [1:0]  o_req_type;
  logic        o_ready;
  logic [10:0] o_brick_cnt;

  int n_chk = 0;
  int n_err = 0;

  map_server #(.MAP_W(40), .MAP_H(30)) dut (
    .clk(clk), .rst_n(rst_n), .i_new_game(i_new_game), .i_vga_busy(i_vga_busy),
    .i_vga_x(i_vga_x), .i_vga_y(i_vga_y), .o_vga_is_wall(o_vga_is_wall),
    .i_req_valid(i_req_valid), .i_req_x(i_req_x), .i_req_y(i_req_y),
    .i_req_clear(i_req_clear), .o_req_ack(o_req_ack), .o_req_type(o_req_type),
    .o_ready(o_ready), .o_brick_cnt(o_brick_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_cell(input int x, input int y);
    if (x >= 40 || y >= 30) return 2;
    if (x == 0 || x == 39 || y == 0 || y == 29) return 2;
    if (x % 8 == 4 && y % 8 == 4) return 2;
    if (x % 4 == 2 && y % 4 == 2) return 1;
    return 0;
  endfunction

  task automatic vga_rd(input int x, input int y, output int w);
    @(negedge clk);
    i_vga_x = 6'(x);
    i_vga_y = 6'(y);
    @(posedge clk);
    @(posedge clk);
    #1 w = int'(o_vga_is_wall);
  endtask

  // lat counts edges from drive until ack is seen
  task automatic do_req(input int x, input int y, input bit clr, output int typ, output int lat);
    @(negedge clk);
    i_req_x = 6'(x); i_req_y = 6'(y); i_req_clear = clr; i_req_valid = 1'b1;
    lat = 0; typ = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 lat++;
      if (o_req_ack) begin
        typ = int'(o_req_type);
        break;
      end
    end
    i_req_valid = 1'b0;
    if (!o_req_ack) chk("req_timeout", 0, 1);
  endtask

  // counts edges until o_ready, also counting any acks seen on the way
  task automatic wait_ready(output int n, output int acks);
    n = 0; acks = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1 n++;
      if (o_req_ack) acks++;
      if (o_ready) break;
    end
    if (!o_ready) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    int w, typ, lat, n, acks, bad;

    #12;
    chk("rst_ready", o_ready, 0);
    chk("rst_ack", o_req_ack, 0);
    chk("rst_type", o_req_type, 0);
    chk("rst_cnt", o_brick_cnt, 0);
    chk("rst_wall", o_vga_is_wall, 0);

    @(negedge clk) rst_n = 1'b1;
    wait_ready(n, acks);
    chk("init_cycles", n, 1200);
    chk("init_cnt", o_brick_cnt, 70);

    bad = 0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++) begin
        vga_rd(x, y, w);
        if (w != (exp_cell(x, y) != 0 ? 1 : 0)) bad++;
      end
    chk("vga_sweep_bad", bad, 0);
    vga_rd(0, 5, w);  chk("vga_0_5", w, 1);
    vga_rd(2, 2, w);  chk("vga_2_2", w, 1);
    vga_rd(1, 1, w);  chk("vga_1_1", w, 0);
    vga_rd(4, 4, w);  chk("vga_4_4", w, 1);
    vga_rd(45, 3, w); chk("vga_oob", w, 1);

    do_req(2, 2, 1, typ, lat);
    chk("clr22_lat", lat, 2);
    chk("clr22_type", typ, 1);
    chk("clr22_cnt", o_brick_cnt, 69);
    do_req(2, 2, 0, typ, lat);
    chk("re22_type", typ, 0);
    chk("re22_cnt", o_brick_cnt, 69);
    vga_rd(2, 2, w);  chk("vga_2_2_clr", w, 0);

    do_req(4, 4, 1, typ, lat);
    chk("clr44_type", typ, 2);
    chk("clr44_cnt", o_brick_cnt, 69);
    do_req(45, 3, 1, typ, lat);
    chk("clroob_type", typ, 2);
    chk("clroob_cnt", o_brick_cnt, 69);
    vga_rd(4, 4, w);  chk("vga_4_4_kept", w, 1);

    // busy hold-off, then release
    @(negedge clk);
    i_vga_busy = 1'b1;
    i_req_x = 6'd6; i_req_y = 6'd6; i_req_clear = 1'b0; i_req_valid = 1'b1;
    acks = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1 if (o_req_ack) acks++;
    end
    chk("busy_noack", acks, 0);
    @(negedge clk) i_vga_busy = 1'b0;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 lat++;
      if (o_req_ack) break;
    end
    i_req_valid = 1'b0;
    chk("busy_rel_lat", lat, 2);
    chk("busy_rel_type", o_req_type, 1);

    // busy rises right after accept: request still completes
    @(negedge clk);
    i_req_x = 6'd0; i_req_y = 6'd0; i_req_clear = 1'b0; i_req_valid = 1'b1;
    @(posedge clk);
    #1 i_vga_busy = 1'b1;
    @(posedge clk);
    #1 chk("busy_late_ack", o_req_ack, 1);
    chk("busy_late_type", o_req_type, 2);
    i_req_valid = 1'b0;
    @(negedge clk) i_vga_busy = 1'b0;

    // new game restores the layout; a request held during INIT waits for ready
    do_req(6, 2, 1, typ, lat);
    chk("clr62_type", typ, 1);
    chk("clr62_cnt", o_brick_cnt, 68);
    @(negedge clk) i_new_game = 1'b1;
    @(posedge clk);
    #1 i_new_game = 1'b0;
    chk("ng_ready_low", o_ready, 0);
    chk("ng_cnt_zero", o_brick_cnt, 0);
    i_req_x = 6'd6; i_req_y = 6'd2; i_req_clear = 1'b0; i_req_valid = 1'b1;
    wait_ready(n, acks);
    chk("ng_cycles", n, 1200);
    chk("ng_noack_init", acks, 0);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 lat++;
      if (o_req_ack) break;
    end
    i_req_valid = 1'b0;
    chk("ng_req_lat", lat, 2);
    chk("ng_62_type", o_req_type, 1);
    chk("ng_cnt", o_brick_cnt, 70);

    // async reset in the middle of an ACCESS
    vga_rd(0, 0, w); chk("pre_rst_wall", w, 1);
    @(negedge clk);
    i_req_x = 6'd2; i_req_y = 6'd2; i_req_clear = 1'b1; i_req_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_ready", o_ready, 0);
    chk("ra_ack", o_req_ack, 0);
    chk("ra_type", o_req_type, 0);
    chk("ra_cnt", o_brick_cnt, 0);
    chk("ra_wall", o_vga_is_wall, 0);
    i_req_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    wait_ready(n, acks);
    chk("ra_cycles", n, 1200);
    chk("ra_noack", acks, 0);
    chk("ra_cnt70", o_brick_cnt, 70);

    // async reset in the middle of the sweep
    @(negedge clk) i_new_game = 1'b1;
    @(negedge clk) i_new_game = 1'b0;
    repeat (150) @(posedge clk);
    #1 chk("rs_cnt_nz", o_brick_cnt != 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_cnt", o_brick_cnt, 0);
    chk("rs_ready", o_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_ready(n, acks);
    chk("rs_cycles", n, 1200);
    chk("rs_cnt70", o_brick_cnt, 70);
    vga_rd(2, 2, w); chk("rs_vga_2_2", w, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
